// File: rtl/esram_pkt_buf_rd_arbiter.sv
// Round-robin, credit-limited arbiter sharing the eSRAM packet-buffer read port between requesters A and B.
// Optional grant/stall statistics counters are compiled in when ESRAM_RD_ARB_STATS_EN is defined.
module esram_pkt_buf_rd_arbiter #(
  parameter int ADDR_WIDTH      = 17,
  parameter int DATA_WIDTH      = 520,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               a_rd_req,
  input  logic [ADDR_WIDTH-1:0]              a_rd_addr,
  output logic                               a_rd_ready,
  output logic                               a_rsp_valid,
  output logic [DATA_WIDTH-1:0]              a_rsp_data,
  input  logic                               b_rd_req,
  input  logic [ADDR_WIDTH-1:0]              b_rd_addr,
  output logic                               b_rd_ready,
  output logic                               b_rsp_valid,
  output logic [DATA_WIDTH-1:0]              b_rsp_data,
  output logic                               esram_rden,
  output logic [ADDR_WIDTH-1:0]              esram_rdaddress,
  input  logic                               esram_rd_valid,
  input  logic [DATA_WIDTH-1:0]              esram_rddata,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding,
  output logic                               err_unexpected_rsp
`ifdef ESRAM_RD_ARB_STATS_EN
  ,
  output logic [31:0]                        stat_a_grants,
  output logic [31:0]                        stat_b_grants,
  output logic [31:0]                        stat_credit_stall
`endif
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;
  localparam logic [CW:0] MAX_CREDIT = (CW+1)'(MAX_OUTSTANDING);

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_e;

  req_e                  last_grant;
  req_e                  last_grant_next;
  logic                  grant_a;
  logic                  grant_b;
  logic                  hs_a;
  logic                  hs_b;
  logic                  credit_ok;

  logic                  rden_q;
  logic [ADDR_WIDTH-1:0] rdaddr_q;
  req_e                  issue_tag_q;

  logic [MAX_OUTSTANDING-1:0] tag_mem;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  pop;

  logic                  rsp_a_q;
  logic                  rsp_b_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  err_q;

  // A read accepted last cycle is already committed but not yet counted in
  // the FIFO, so it has to be charged against the credit here.
  assign credit_ok = ({1'b0, count} + (CW+1)'(rden_q)) < MAX_CREDIT;

  // A pop may only consume an entry that existed before this cycle.
  assign pop = esram_rd_valid && (count != '0);

  // NOTE: every combinational output gets a default first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    grant_a         = 1'b0;
    grant_b         = 1'b0;
    last_grant_next = last_grant;
    unique case ({a_rd_req, b_rd_req})
      2'b10:   grant_a = 1'b1;
      2'b01:   grant_b = 1'b1;
      2'b11: begin
        if (last_grant == REQ_B) grant_a = 1'b1;
        else                     grant_b = 1'b1;
      end
      default: ;
    endcase
    hs_a = grant_a && credit_ok;
    hs_b = grant_b && credit_ok;
    if (hs_a)      last_grant_next = REQ_A;
    else if (hs_b) last_grant_next = REQ_B;
  end

  assign a_rd_ready = grant_a && credit_ok;
  assign b_rd_ready = grant_b && credit_ok;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) last_grant <= REQ_B;
    else     last_grant <= last_grant_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rden_q      <= 1'b0;
      rdaddr_q    <= '0;
      issue_tag_q <= REQ_A;
    end else begin
      rden_q <= hs_a || hs_b;
      if (hs_a) begin
        rdaddr_q    <= a_rd_addr;
        issue_tag_q <= REQ_A;
      end else if (hs_b) begin
        rdaddr_q    <= b_rd_addr;
        issue_tag_q <= REQ_B;
      end
    end
  end

  // NOTE: tag storage carries no reset; the pointers and count define which
  // entries are valid, so clearing those alone empties the FIFO.
  always_ff @(posedge clk) begin
    if (rden_q) tag_mem[wr_ptr] <= issue_tag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (rden_q) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      unique case ({rden_q, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_a_q    <= 1'b0;
      rsp_b_q    <= 1'b0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rsp_a_q <= pop && (tag_mem[rd_ptr] == REQ_A);
      rsp_b_q <= pop && (tag_mem[rd_ptr] == REQ_B);
      if (pop) rsp_data_q <= esram_rddata;
      if (esram_rd_valid && (count == '0)) err_q <= 1'b1;
    end
  end

  assign esram_rden         = rden_q;
  assign esram_rdaddress    = rdaddr_q;
  assign outstanding        = count;
  assign a_rsp_valid        = rsp_a_q;
  assign b_rsp_valid        = rsp_b_q;
  assign a_rsp_data         = rsp_data_q;
  assign b_rsp_data         = rsp_data_q;
  assign err_unexpected_rsp = err_q;

`ifdef ESRAM_RD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_a_grants     <= '0;
      stat_b_grants     <= '0;
      stat_credit_stall <= '0;
    end else begin
      if (hs_a && (stat_a_grants != '1)) stat_a_grants <= stat_a_grants + 1'b1;
      if (hs_b && (stat_b_grants != '1)) stat_b_grants <= stat_b_grants + 1'b1;
      if ((a_rd_req || b_rd_req) && !credit_ok && (stat_credit_stall != '1))
        stat_credit_stall <= stat_credit_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_esram_pkt_buf_rd_arbiter.sv
// Self-checking bench for esram_pkt_buf_rd_arbiter: an in-order eSRAM model plus a
// transaction-level reference (accepted-read queue, credit count, round-robin pointer).
module tb_esram_pkt_buf_rd_arbiter;

  localparam int AW  = 17;
  localparam int DW  = 520;
  localparam int MAX = 16;
  localparam int CW  = $clog2(MAX) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_rd_req = 1'b0;
  logic [AW-1:0] a_rd_addr = '0;
  logic          a_rd_ready;
  logic          a_rsp_valid;
  logic [DW-1:0] a_rsp_data;
  logic          b_rd_req = 1'b0;
  logic [AW-1:0] b_rd_addr = '0;
  logic          b_rd_ready;
  logic          b_rsp_valid;
  logic [DW-1:0] b_rsp_data;
  logic          esram_rden;
  logic [AW-1:0] esram_rdaddress;
  logic          esram_rd_valid = 1'b0;
  logic [DW-1:0] esram_rddata = '0;
  logic [CW-1:0] outstanding;
  logic          err_unexpected_rsp;
`ifdef ESRAM_RD_ARB_STATS_EN
  logic [31:0]   stat_a_grants;
  logic [31:0]   stat_b_grants;
  logic [31:0]   stat_credit_stall;
`endif

  esram_pkt_buf_rd_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .a_rd_req(a_rd_req), .a_rd_addr(a_rd_addr), .a_rd_ready(a_rd_ready),
    .a_rsp_valid(a_rsp_valid), .a_rsp_data(a_rsp_data),
    .b_rd_req(b_rd_req), .b_rd_addr(b_rd_addr), .b_rd_ready(b_rd_ready),
    .b_rsp_valid(b_rsp_valid), .b_rsp_data(b_rsp_data),
    .esram_rden(esram_rden), .esram_rdaddress(esram_rdaddress),
    .esram_rd_valid(esram_rd_valid), .esram_rddata(esram_rddata),
    .outstanding(outstanding), .err_unexpected_rsp(err_unexpected_rsp)
`ifdef ESRAM_RD_ARB_STATS_EN
    , .stat_a_grants(stat_a_grants), .stat_b_grants(stat_b_grants),
    .stat_credit_stall(stat_credit_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_b;
    logic [AW-1:0] addr;
    int            issue;
  } acc_t;

  typedef struct {
    logic [AW-1:0] addr;
    int            ret;
  } mem_t;

  acc_t          acc_q[$];
  mem_t          mem_q[$];
  int            cyc;
  int            last_ret;
  int            lat_min;
  int            lat_max;
  int            checks;
  int            errors;
  int            obs_hs;
  bit            last_b;
  bit            exp_rden;
  logic [AW-1:0] exp_addr;
  bit            exp_rsp_a;
  bit            exp_rsp_b;
  logic [DW-1:0] exp_data;
  bit            exp_err;
  int            m_a_grants;
  int            m_b_grants;
  int            m_stall;

  function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < (DW + 31) / 32; i++)
      d = (d << 32) | DW'((32'(a) ^ 32'hAB00_0000) * 32'h9E37_79B1 + 32'(i));
    return d;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, emulate the eSRAM, compare, advance the model.
  task automatic step(input logic ar, input logic [AW-1:0] aa, input logic br,
                      input logic [AW-1:0] ba, input bit withhold, input bit inject);
    int   exp_out;
    bit   credit, ga, gb;
    acc_t e;
    mem_t m;
    @(negedge clk);
    a_rd_req  = ar;
    a_rd_addr = aa;
    b_rd_req  = br;
    b_rd_addr = ba;
    if (inject) begin
      esram_rd_valid = 1'b1;
      esram_rddata   = DW'({$urandom, $urandom});
    end else if (!withhold && mem_q.size() > 0 && mem_q[0].ret <= cyc) begin
      m = mem_q.pop_front();
      esram_rd_valid = 1'b1;
      esram_rddata   = mem_data(m.addr);
    end else begin
      esram_rd_valid = 1'b0;
      esram_rddata   = DW'($urandom);
    end
    if (esram_rden) begin
      m.addr = esram_rdaddress;
      m.ret  = cyc + int'($urandom_range(lat_max, lat_min));
      if (m.ret <= last_ret) m.ret = last_ret + 1;
      last_ret = m.ret;
      mem_q.push_back(m);
    end
    #1;
    exp_out = 0;
    foreach (acc_q[i]) if (acc_q[i].issue < cyc) exp_out++;
    credit = acc_q.size() < MAX;
    ga = ar && (!br || last_b);
    gb = br && (!ar || !last_b);
    check("a_rd_ready", DW'(a_rd_ready), DW'(ga && credit));
    check("b_rd_ready", DW'(b_rd_ready), DW'(gb && credit));
    check("esram_rden", DW'(esram_rden), DW'(exp_rden));
    check("esram_rdaddress", DW'(esram_rdaddress), DW'(exp_addr));
    check("outstanding", DW'(outstanding), DW'(exp_out));
    check("a_rsp_valid", DW'(a_rsp_valid), DW'(exp_rsp_a));
    check("b_rsp_valid", DW'(b_rsp_valid), DW'(exp_rsp_b));
    check("err_unexpected_rsp", DW'(err_unexpected_rsp), DW'(exp_err));
    if (exp_rsp_a) check("a_rsp_data", a_rsp_data, exp_data);
    if (exp_rsp_b) check("b_rsp_data", b_rsp_data, exp_data);
`ifdef ESRAM_RD_ARB_STATS_EN
    check("stat_a_grants", DW'(stat_a_grants), DW'(m_a_grants));
    check("stat_b_grants", DW'(stat_b_grants), DW'(m_b_grants));
    check("stat_credit_stall", DW'(stat_credit_stall), DW'(m_stall));
`endif
    if ((a_rd_ready && ar) || (b_rd_ready && br)) obs_hs++;

    exp_rsp_a = 1'b0;
    exp_rsp_b = 1'b0;
    if (esram_rd_valid) begin
      if (acc_q.size() > 0 && acc_q[0].issue < cyc) begin
        e = acc_q.pop_front();
        exp_rsp_a = !e.is_b;
        exp_rsp_b = e.is_b;
        exp_data  = mem_data(e.addr);
      end else begin
        exp_err = 1'b1;
      end
    end
    exp_rden = 1'b0;
    if (credit && (ga || gb)) begin
      e.is_b  = gb;
      e.addr  = gb ? ba : aa;
      e.issue = cyc + 1;
      acc_q.push_back(e);
      last_b   = gb;
      exp_rden = 1'b1;
      exp_addr = e.addr;
      if (gb) m_b_grants++;
      else    m_a_grants++;
    end
    if ((ar || br) && !credit) m_stall++;
    cyc++;
  endtask

  task automatic idle(input int n, input bit withhold);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, withhold, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    a_rd_req       = 1'b0;
    b_rd_req       = 1'b0;
    esram_rd_valid = 1'b0;
    @(negedge clk);
    #1;
    check("rst_a_rd_ready", DW'(a_rd_ready), '0);
    check("rst_b_rd_ready", DW'(b_rd_ready), '0);
    check("rst_esram_rden", DW'(esram_rden), '0);
    check("rst_esram_rdaddress", DW'(esram_rdaddress), '0);
    check("rst_a_rsp_valid", DW'(a_rsp_valid), '0);
    check("rst_b_rsp_valid", DW'(b_rsp_valid), '0);
    check("rst_a_rsp_data", a_rsp_data, '0);
    check("rst_b_rsp_data", b_rsp_data, '0);
    check("rst_outstanding", DW'(outstanding), '0);
    check("rst_err", DW'(err_unexpected_rsp), '0);
`ifdef ESRAM_RD_ARB_STATS_EN
    check("rst_stat_a", DW'(stat_a_grants), '0);
    check("rst_stat_b", DW'(stat_b_grants), '0);
    check("rst_stat_stall", DW'(stat_credit_stall), '0);
`endif
    rst = 1'b0;
    cyc += 2;
    acc_q.delete();
    mem_q.delete();
    last_ret   = 0;
    last_b     = 1'b1;
    exp_rden   = 1'b0;
    exp_addr   = '0;
    exp_rsp_a  = 1'b0;
    exp_rsp_b  = 1'b0;
    exp_err    = 1'b0;
    m_a_grants = 0;
    m_b_grants = 0;
    m_stall    = 0;
  endtask

  initial begin
    int hs_mark;
    int n;
    checks  = 0;
    errors  = 0;
    obs_hs  = 0;
    cyc     = 0;
    lat_min = 2;
    lat_max = 2;
    do_reset();

    // Single read from A: ready, issue next cycle, response 1 cycle after return.
    step(1'b1, 17'h00010, 1'b0, '0, 1'b0, 1'b0);
    idle(4, 1'b0);
    check("single_a_rsp_valid", DW'(a_rsp_valid), DW'(1));
    check("single_a_rsp_data", a_rsp_data, mem_data(17'h00010));
    idle(3, 1'b0);

    // Contention from reset: A wins first, then strict alternation.
    do_reset();
    lat_min = 1;
    lat_max = 3;
    for (int i = 0; i < 8; i++)
      step(1'b1, AW'($urandom), 1'b1, AW'($urandom), 1'b0, 1'b0);
    idle(20, 1'b0);

    // Credit limit: returns withheld, both requesting continuously.
    hs_mark = obs_hs;
    for (int i = 0; i < 24; i++)
      step(1'b1, AW'($urandom), 1'b1, AW'($urandom), 1'b1, 1'b0);
    check("credit_handshakes", DW'(obs_hs - hs_mark), DW'(MAX));
    check("credit_full_outstanding", DW'(outstanding), DW'(MAX));
    check("credit_full_ready", DW'(a_rd_ready || b_rd_ready), '0);
    hs_mark = obs_hs;
    step(1'b1, AW'($urandom), 1'b1, AW'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)
      step(1'b1, AW'($urandom), 1'b1, AW'($urandom), 1'b1, 1'b0);
    check("credit_one_more", DW'(obs_hs - hs_mark), DW'(1));
    idle(40, 1'b0);

    // Randomised mix of requesters, latencies and return stalls.
    lat_min = 1;
    lat_max = 4;
    hs_mark = obs_hs;
    n = 0;
    while ((obs_hs - hs_mark) < 100 && n < 3000) begin
      step(1'($urandom), AW'($urandom), 1'($urandom), AW'($urandom),
           ($urandom_range(9, 0) == 0), 1'b0);
      n++;
    end
    check("random_reads_done", DW'((obs_hs - hs_mark) >= 100), DW'(1));
    idle(40, 1'b0);
    check("random_drained", DW'(outstanding), '0);

    // Return with nothing in flight: dropped, sticky error, count stays 0.
    step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    idle(4, 1'b0);
    check("unexp_err_held", DW'(err_unexpected_rsp), DW'(1));
    check("unexp_outstanding", DW'(outstanding), '0);

    // Reset with five reads in flight, then a fresh read must complete.
    lat_min = 2;
    lat_max = 2;
    for (int i = 0; i < 5; i++)
      step(1'b1, AW'($urandom), 1'b0, '0, 1'b1, 1'b0);
    idle(2, 1'b1);
    check("midflight_outstanding", DW'(outstanding), DW'(5));
    do_reset();
    step(1'b0, '0, 1'b1, 17'h1ABCD, 1'b0, 1'b0);
    idle(4, 1'b0);
    check("post_rst_b_rsp_valid", DW'(b_rsp_valid), DW'(1));
    check("post_rst_b_rsp_data", b_rsp_data, mem_data(17'h1ABCD));
    idle(3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
